// File: rtl/xilinx_clock_monitor_if.sv
// Status bundle between the clock monitor and its debug/LED consumer.
// master: monitor side (cfg, cog_tgl in; measurement status out). slave: consumer side.
interface xilinx_clock_monitor_if #(
    parameter int WINDOW_LOG2 = 10
);
    logic [6:0]             cfg;
    logic                   cog_tgl;
    logic [WINDOW_LOG2-1:0] meas_count;
    logic [2:0]             det_mode;
    logic [2:0]             exp_mode;
    logic                   meas_done;
    logic                   valid;
    logic                   locked;
    logic                   mismatch;

    modport master (
        input  cfg, cog_tgl,
        output meas_count, det_mode, exp_mode,
        output meas_done, valid, locked, mismatch
    );

    modport slave (
        output cfg, cog_tgl,
        input  meas_count, det_mode, exp_mode,
        input  meas_done, valid, locked, mismatch
    );
endinterface

// File: rtl/xilinx_clock_monitor.sv
// Closed-loop frequency check of the cog clock against the CLK register mode.
// Ports: clock_160, nres (sync, active-low), mon (cfg/cog_tgl in, status out).
module xilinx_clock_monitor #(
    parameter int WINDOW_LOG2 = 10,
    parameter int TOL         = 4,
    parameter int SETTLE      = 3
) (
    input  logic                   clock_160,
    input  logic                   nres,
    xilinx_clock_monitor_if.master mon
);
    localparam int W  = WINDOW_LOG2;
    localparam int RW = $clog2(SETTLE + 1);

    localparam logic [2:0] M_RCSLOW = 3'd0;
    localparam logic [2:0] M_X1     = 3'd1;
    localparam logic [2:0] M_X2     = 3'd2;
    localparam logic [2:0] M_X4     = 3'd3;
    localparam logic [2:0] M_X8     = 3'd4;
    localparam logic [2:0] M_X16    = 3'd5;
    localparam logic [2:0] M_UNK    = 3'd7;

    typedef enum logic [1:0] {
        HOLDOFF,
        MEASURE,
        EVAL
    } state_t;

    // An all-zero selector is the RCSLOW reset encoding, not a PLL x2.
    function automatic logic [2:0] cfg_mode(input logic [6:0] c);
        logic [4:0] sel;
        sel = {c[6:5], c[2:0]};
        cfg_mode = M_RCSLOW;
        if (sel == 5'b11111)
            cfg_mode = M_X16;
        else if (sel == 5'b11110)
            cfg_mode = M_X8;
        else if (sel == 5'b11101)
            cfg_mode = M_X4;
        else if (sel == 5'b11100 ||
                 (sel[2:0] == 3'b000 && sel[4:3] != 2'b00))
            cfg_mode = M_X2;
        else if (sel == 5'b11011 || sel == 5'b01010)
            cfg_mode = M_X1;
    endfunction

    // Lowest mode within tolerance wins; scanned high to low so it overwrites.
    function automatic logic [2:0] cnt_mode(input logic [W-1:0] n);
        logic [W:0] c;
        logic [W:0] tol;
        logic [W:0] nom;
        c   = {1'b0, n};
        tol = (W+1)'(TOL);
        cnt_mode = M_UNK;
        for (int k = 4; k >= 0; k--) begin
            nom = (W+1)'(1) << (W - 5 + k);
            if (c + tol >= nom && c <= nom + tol)
                cnt_mode = 3'(k + 1);
        end
        if (c <= tol)
            cnt_mode = M_RCSLOW;
    endfunction

    state_t         state;
    state_t         state_d;
    logic           tgl_s1;
    logic           tgl_s2;
    logic           tgl_s3;
    logic [6:0]     cfg_q;
    logic [W-1:0]   win;
    logic [W-1:0]   tcnt;
    logic [RW-1:0]  match_run;
    logic [RW-1:0]  miss_run;
    logic [RW-1:0]  match_nx;
    logic [RW-1:0]  miss_nx;
    logic [2:0]     det_now;
    logic           edge_det;
    logic           cfg_chg;
    logic           win_end;
    logic           counting;
    logic           do_eval;
    logic           hit;

    assign edge_det = tgl_s2 ^ tgl_s3;
    assign cfg_chg  = mon.cfg != cfg_q;
    assign win_end  = &win;
    assign det_now  = cnt_mode(tcnt);
    assign hit      = det_now == mon.exp_mode;

    always_comb begin
        state_d  = state;
        counting = 1'b0;
        do_eval  = 1'b0;
        if (cfg_chg) begin
            state_d = HOLDOFF;
        end else begin
            unique case (state)
                HOLDOFF: begin
                    if (win_end)
                        state_d = MEASURE;
                end
                MEASURE: begin
                    counting = 1'b1;
                    if (win_end)
                        state_d = EVAL;
                end
                EVAL: begin
                    do_eval = 1'b1;
                    state_d = MEASURE;
                end
                default: state_d = HOLDOFF;
            endcase
        end
    end

    always_comb begin
        match_nx = '0;
        miss_nx  = '0;
        if (hit)
            match_nx = (match_run == RW'(SETTLE)) ?
                       match_run : match_run + 1'b1;
        else
            miss_nx = (miss_run == RW'(SETTLE)) ?
                      miss_run : miss_run + 1'b1;
    end

    // Synchronizer and cfg shadow run through reset so a steady cfg
    // never looks like a change once reset is released.
    always_ff @(posedge clock_160) begin
        tgl_s1 <= mon.cog_tgl;
        tgl_s2 <= tgl_s1;
        tgl_s3 <= tgl_s2;
        cfg_q  <= mon.cfg;
        if (!nres) begin
            state          <= HOLDOFF;
            win            <= '0;
            tcnt           <= '0;
            match_run      <= '0;
            miss_run       <= '0;
            mon.meas_count <= '0;
            mon.det_mode   <= M_UNK;
            mon.exp_mode   <= cfg_mode(7'd0);
            mon.meas_done  <= 1'b0;
            mon.valid      <= 1'b0;
            mon.locked     <= 1'b0;
            mon.mismatch   <= 1'b0;
        end else begin
            state         <= state_d;
            mon.exp_mode  <= cfg_mode(mon.cfg);
            mon.meas_done <= do_eval;
            if (cfg_chg) begin
                win          <= '0;
                tcnt         <= '0;
                match_run    <= '0;
                miss_run     <= '0;
                mon.valid    <= 1'b0;
                mon.locked   <= 1'b0;
                mon.mismatch <= 1'b0;
            end else if (do_eval) begin
                win            <= '0;
                tcnt           <= '0;
                mon.meas_count <= tcnt;
                mon.det_mode   <= det_now;
                mon.valid      <= 1'b1;
                match_run      <= match_nx;
                miss_run       <= miss_nx;
                mon.locked     <= match_nx == RW'(SETTLE);
                mon.mismatch   <= miss_nx == RW'(SETTLE);
            end else begin
                win <= win + 1'b1;
                if (counting && edge_det && !(&tcnt))
                    tcnt <= tcnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_xilinx_clock_monitor.sv
// Directed bench for xilinx_clock_monitor with default parameters.
// Vector tables for cfg decode and steady-rate windows, plus corner sequences.
module tb_xilinx_clock_monitor;
    localparam logic [6:0] C_X16 = 7'b1100111;
    localparam logic [6:0] C_X8  = 7'b1100110;

    logic clk;
    logic nres;
    int   total;
    int   passed;
    int   per;
    int   burst_len;
    int   burst_seq;
    int   n;

    xilinx_clock_monitor_if #(.WINDOW_LOG2(10)) bus ();

    xilinx_clock_monitor #(
        .WINDOW_LOG2(10),
        .TOL(4),
        .SETTLE(3)
    ) dut (
        .clock_160(clk),
        .nres(nres),
        .mon(bus)
    );

    typedef struct {
        logic [6:0] cfg;
        logic [2:0] exp;
    } cfg_vec_t;

    typedef struct {
        logic [6:0] cfg;
        int         per;
        bit         chk_cnt;
        int         cnt;
        int         det;
        int         exp;
        bit         lock;
        bit         mism;
    } win_vec_t;

    cfg_vec_t cv [10];
    win_vec_t wv [7];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sole driver of cog_tgl: a burst of back-to-back toggles takes
    // precedence, otherwise one toggle every 'per' cycles (0 = static).
    initial begin
        int cnt;
        int seen;
        int left;
        cnt = 0;
        seen = 0;
        left = 0;
        bus.cog_tgl = 1'b0;
        forever begin
            @(negedge clk);
            if (burst_seq != seen) begin
                seen = burst_seq;
                left = burst_len;
            end
            if (left > 0) begin
                bus.cog_tgl = ~bus.cog_tgl;
                left--;
            end else if (per > 0) begin
                cnt++;
                if (cnt >= per) begin
                    bus.cog_tgl = ~bus.cog_tgl;
                    cnt = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
    endtask

    task automatic wait_done(input string nm, input int max,
                             output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!bus.meas_done && cyc < max);
        if (!bus.meas_done) begin
            total++;
            $display("FAIL %s: no meas_done within %0d cycles", nm, max);
        end
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_count"}, 32'(bus.meas_count), 0);
        chk({nm, "_det"}, 32'(bus.det_mode), 7);
        chk({nm, "_exp"}, 32'(bus.exp_mode), 0);
        chk({nm, "_done"}, 32'(bus.meas_done), 0);
        chk({nm, "_valid"}, 32'(bus.valid), 0);
        chk({nm, "_locked"}, 32'(bus.locked), 0);
        chk({nm, "_mismatch"}, 32'(bus.mismatch), 0);
    endtask

    task automatic restart(input logic [6:0] c, input int p);
        bus.cfg = ~c;
        tick();
        bus.cfg = c;
        per = p;
        tick();
    endtask

    initial begin
        total = 0;
        passed = 0;
        per = 0;
        burst_len = 0;
        burst_seq = 0;
        nres = 1'b0;
        bus.cfg = 7'd0;

        cv[0] = '{7'b0000000, 3'd0};
        cv[1] = '{7'b1100111, 3'd5};
        cv[2] = '{7'b1100110, 3'd4};
        cv[3] = '{7'b1100101, 3'd3};
        cv[4] = '{7'b1100100, 3'd2};
        cv[5] = '{7'b1100011, 3'd1};
        cv[6] = '{7'b0100010, 3'd1};
        cv[7] = '{7'b0000001, 3'd0};
        cv[8] = '{7'b1000111, 3'd0};
        cv[9] = '{7'b0011111, 3'd0};

        wv[0] = '{C_X16,      2,  1'b1, 512, 5, 5, 1'b1, 1'b0};
        wv[1] = '{C_X16,      16, 1'b1, 64,  2, 5, 1'b0, 1'b1};
        wv[2] = '{7'b0000000, 0,  1'b1, 0,   0, 0, 1'b1, 1'b0};
        wv[3] = '{7'b1100101, 8,  1'b1, 128, 3, 3, 1'b1, 1'b0};
        wv[4] = '{7'b1100011, 32, 1'b1, 32,  1, 1, 1'b1, 1'b0};
        wv[5] = '{C_X8,       4,  1'b1, 256, 4, 4, 1'b1, 1'b0};
        wv[6] = '{C_X16,      3,  1'b0, 0,   7, 5, 1'b0, 1'b1};

        tick();
        tick();
        chk_reset("reset");
        nres = 1'b1;

        foreach (cv[i]) begin
            bus.cfg = cv[i].cfg;
            tick();
            chk($sformatf("cfg%0d_exp", i), 32'(bus.exp_mode),
                32'(cv[i].exp));
            chk($sformatf("cfg%0d_valid", i), 32'(bus.valid), 0);
        end

        foreach (wv[i]) begin
            restart(wv[i].cfg, wv[i].per);
            chk($sformatf("win%0d_valid0", i), 32'(bus.valid), 0);
            for (int w = 0; w < 3; w++) begin
                wait_done($sformatf("win%0d_%0d", i, w), 2200, n);
                if (wv[i].chk_cnt)
                    chk($sformatf("win%0d_%0d_count", i, w),
                        32'(bus.meas_count), 32'(wv[i].cnt));
                chk($sformatf("win%0d_%0d_det", i, w),
                    32'(bus.det_mode), 32'(wv[i].det));
                chk($sformatf("win%0d_%0d_exp", i, w),
                    32'(bus.exp_mode), 32'(wv[i].exp));
                if (w < 2) begin
                    chk($sformatf("win%0d_%0d_lock", i, w),
                        32'(bus.locked), 0);
                    chk($sformatf("win%0d_%0d_mism", i, w),
                        32'(bus.mismatch), 0);
                end else begin
                    chk($sformatf("win%0d_lock", i),
                        32'(bus.locked), 32'(wv[i].lock));
                    chk($sformatf("win%0d_mism", i),
                        32'(bus.mismatch), 32'(wv[i].mism));
                end
            end
        end

        restart(C_X16, 0);
        wait_done("tol_idle", 2200, n);
        chk("tol_idle_count", 32'(bus.meas_count), 0);
        burst_len = 516;
        burst_seq++;
        wait_done("tol516", 1100, n);
        chk("tol516_count", 32'(bus.meas_count), 516);
        chk("tol516_det", 32'(bus.det_mode), 5);
        burst_len = 517;
        burst_seq++;
        wait_done("tol517", 1100, n);
        chk("tol517_count", 32'(bus.meas_count), 517);
        chk("tol517_det", 32'(bus.det_mode), 7);
        per = 1;
        wait_done("sat_a", 1100, n);
        wait_done("sat_b", 1100, n);
        chk("sat_count", 32'(bus.meas_count), 1023);
        chk("sat_det", 32'(bus.det_mode), 7);

        restart(C_X16, 2);
        for (int w = 0; w < 3; w++)
            wait_done("prelock", 2200, n);
        chk("prelock_locked", 32'(bus.locked), 1);
        repeat (300) tick();
        bus.cfg = C_X8;
        tick();
        chk("chg_valid", 32'(bus.valid), 0);
        chk("chg_locked", 32'(bus.locked), 0);
        chk("chg_exp", 32'(bus.exp_mode), 4);
        chk("chg_done", 32'(bus.meas_done), 0);
        wait_done("chg_first", 2200, n);
        chk("chg_holdoff_len", 32'(n), 2049);
        chk("chg_count", 32'(bus.meas_count), 512);
        chk("chg_det", 32'(bus.det_mode), 5);
        chk("chg_valid1", 32'(bus.valid), 1);
        chk("chg_locked1", 32'(bus.locked), 0);
        repeat (1024) tick();
        bus.cfg = C_X16;
        tick();
        chk("eval_chg_done", 32'(bus.meas_done), 0);
        chk("eval_chg_valid", 32'(bus.valid), 0);
        chk("eval_chg_exp", 32'(bus.exp_mode), 5);
        wait_done("eval_chg_first", 2200, n);
        chk("eval_chg_len", 32'(n), 2049);
        tick();
        chk("done_pulse", 32'(bus.meas_done), 0);

        repeat (498) tick();
        nres = 1'b0;
        tick();
        chk_reset("midrst");
        nres = 1'b1;
        wait_done("rst_first", 2200, n);
        chk("rst_len", 32'(n), 2049);
        chk("rst_count", 32'(bus.meas_count), 512);
        chk("rst_det", 32'(bus.det_mode), 5);
        chk("rst_exp", 32'(bus.exp_mode), 5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
